r_tile_read_sequencer: RTL

- Sits directly upstream of one register bank tile (one of 4 banks, 32 regs each, global regs G[0-127]).
- Accepts block read-queue entries {block_id, queue_id R[0-31], reg_id G[0-127]} from the global control tile through a small FIFO.
- Issues them one at a time to the bank's read_req/reg_id/queue_id port and collects ack/read_data.
- Forwards each returned value as an operand packet to the operand network. Supports per-block flush of in-flight reads.

---
 rtl/r_tile_read_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/r_tile_read_sequencer.sv
// Read sequencer for one register bank tile: queues read entries, issues them one at a time to the
// bank and forwards results as operand packets; per-block flush kills queued and in-flight reads.
module r_tile_read_sequencer #(
    parameter int BANK_ID     = 0,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int BLOCK_ID_W  = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_ID_W-1:0] in_block_id,
    input  logic [4:0]            in_queue_id,
    input  logic [6:0]            in_reg_id,
    input  logic                  flush_valid,
    input  logic [BLOCK_ID_W-1:0] flush_block_id,
    output logic                  bank_read_req,
    output logic [6:0]            bank_reg_id,
    output logic [4:0]            bank_queue_id,
    input  logic                  bank_ack,
    input  logic                  bank_alignment_err,
    input  logic [DATA_W-1:0]     bank_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_ID_W-1:0] out_block_id,
    output logic [4:0]            out_queue_id,
    output logic [DATA_W-1:0]     out_data,
    output logic                  err_valid,
    output logic [1:0]            err_code,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;

    logic [BLOCK_ID_W-1:0] fifo_blk_q [FIFO_DEPTH];
    logic [4:0]            fifo_qid_q [FIFO_DEPTH];
    logic [6:0]            fifo_reg_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill_q, kill_d;
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic                  empty, full, pop, push, reject, push_hs, flush_hit_in, head_killed;

    state_t                state_q, state_d;
    logic [BLOCK_ID_W-1:0] cur_blk_q, cur_blk_d;
    logic [4:0]            cur_qid_q, cur_qid_d;
    logic [6:0]            cur_reg_q, cur_reg_d;
    logic                  cur_kill_q, cur_kill_d, flush_hit_cur;
    logic                  err_latch_q, err_latch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  fsm_err;
    logic [1:0]            fsm_err_code;
    logic                  err_vld_q, err_vld_d, rej_pend_q, rej_pend_d;
    logic [1:0]            err_code_q, err_code_d;

    assign wr_idx       = wr_ptr_q[AW-1:0];
    assign rd_idx       = rd_ptr_q[AW-1:0];
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign pop          = (state_q == S_IDLE) && !empty;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign in_ready     = !full || pop;
    assign push_hs      = in_valid && in_ready;
    assign push         = push_hs && (in_reg_id[1:0] == 2'(BANK_ID));
    assign reject       = push_hs && (in_reg_id[1:0] != 2'(BANK_ID));
    assign flush_hit_in = flush_valid && (in_block_id == flush_block_id);
    assign head_killed  = kill_q[rd_idx] || (flush_valid && (fifo_blk_q[rd_idx] == flush_block_id));
    assign flush_hit_cur = flush_valid && (cur_blk_q == flush_block_id) && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_blk_q[wr_idx] <= in_block_id;
            fifo_qid_q[wr_idx] <= in_queue_id;
            fifo_reg_q[wr_idx] <= in_reg_id;
        end
    end

    // Pushed entry's kill bit overwrites whatever a stale flush left in that slot.
    always_comb begin
        kill_d = kill_q;
        if (flush_valid) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (fifo_blk_q[i] == flush_block_id) kill_d[i] = 1'b1;
            end
        end
        if (pop)  kill_d[rd_idx] = 1'b0;
        if (push) kill_d[wr_idx] = flush_hit_in;
    end

    always_comb begin
        state_d       = state_q;
        cur_blk_d     = cur_blk_q;
        cur_qid_d     = cur_qid_q;
        cur_reg_d     = cur_reg_q;
        cur_kill_d    = cur_kill_q || flush_hit_cur;
        err_latch_d   = err_latch_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        fsm_err       = 1'b0;
        fsm_err_code  = 2'b00;
        bank_read_req = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    cur_blk_d  = fifo_blk_q[rd_idx];
                    cur_qid_d  = fifo_qid_q[rd_idx];
                    cur_reg_d  = fifo_reg_q[rd_idx];
                    cur_kill_d = 1'b0;
                    if (!head_killed) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bank_read_req = 1'b1;
                err_latch_d   = bank_alignment_err;
                cnt_d         = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bank_ack) begin
                    if (err_latch_q) begin
                        fsm_err      = 1'b1;
                        fsm_err_code = 2'b10;
                        state_d      = S_IDLE;
                    end else begin
                        data_d  = bank_read_data;
                        state_d = cur_kill_d ? S_IDLE : S_SEND;
                    end
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    fsm_err      = 1'b1;
                    fsm_err_code = 2'b11;
                    state_d      = S_IDLE;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready || cur_kill_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM errors take the pulse; a colliding reject is held one cycle.
    always_comb begin
        err_vld_d  = 1'b0;
        err_code_d = 2'b00;
        rej_pend_d = rej_pend_q;
        if (fsm_err) begin
            err_vld_d  = 1'b1;
            err_code_d = fsm_err_code;
            rej_pend_d = rej_pend_q || reject;
        end else if (rej_pend_q || reject) begin
            err_vld_d  = 1'b1;
            err_code_d = 2'b01;
            rej_pend_d = rej_pend_q && reject;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            kill_q      <= '0;
            state_q     <= S_IDLE;
            cur_blk_q   <= '0;
            cur_qid_q   <= '0;
            cur_reg_q   <= '0;
            cur_kill_q  <= 1'b0;
            err_latch_q <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            err_vld_q   <= 1'b0;
            err_code_q  <= 2'b00;
            rej_pend_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            kill_q      <= kill_d;
            state_q     <= state_d;
            cur_blk_q   <= cur_blk_d;
            cur_qid_q   <= cur_qid_d;
            cur_reg_q   <= cur_reg_d;
            cur_kill_q  <= cur_kill_d;
            err_latch_q <= err_latch_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            err_vld_q   <= err_vld_d;
            err_code_q  <= err_code_d;
            rej_pend_q  <= rej_pend_d;
        end
    end

    assign bank_reg_id   = cur_reg_q;
    assign bank_queue_id = cur_qid_q;
    assign out_block_id  = cur_blk_q;
    assign out_queue_id  = cur_qid_q;
    assign out_data      = data_q;
    assign err_valid     = err_vld_q;
    assign err_code      = err_code_q;
    assign busy          = !empty || (state_q != S_IDLE);
endmodule
